// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit register file with two combinational
// read ports, one write port and optional write-to-read forwarding.
module reg_file #(
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [32];
    logic        wr_ok;
    logic        hit1;
    logic        hit2;

    // A write lands only outside reset, when enabled, and never on x0
    assign wr_ok = !rst && we && (wa != 5'd0);

    // Forwarding hits are per port and vanish when BYPASS is 0
    assign hit1 = (BYPASS != 0) && wr_ok && (wa == ra1);
    assign hit2 = (BYPASS != 0) && wr_ok && (wa == ra2);

    // Storage update: reset clears everything and beats any write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wa] <= wd;
        end
    end

    // Read port 1: x0 is hard zero, forwarded data wins over storage
    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == 5'd0) begin
            rd1 = '0;
        end else if (hit1) begin
            rd1 = wd;
        end
    end

    // Read port 2: same selection as port 1, independent address
    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == 5'd0) begin
            rd2 = '0;
        end else if (hit2) begin
            rd2 = wd;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed checks of reg_file with forwarding on
// (dut) and off (dut0), both driven by the same stimulus.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] q1;
    logic [31:0] q2;

    int total;
    int bad;

    reg_file #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .we(we), .wa(wa), .wd(wd)
    );

    reg_file #(.BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2),
        .rd1(q1), .rd2(q2), .we(we), .wa(wa), .wd(wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        we  = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            total++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                bad++;
                $display("FAIL reset_sweep i=%0d got rd1=%h rd2=%h exp 0",
                         i, rd1, rd2);
            end
            total++;
            if (q1 !== 32'h0 || q2 !== 32'h0) begin
                bad++;
                $display("FAIL reset_sweep_nb i=%0d got %h %h exp 0",
                         i, q1, q2);
            end
        end
    endtask

    task automatic test_write_read();
        we = 1'b1;
        wa = 5'd5;
        wd = 32'hDEAD_BEEF;
        ra1 = 5'd1;
        ra2 = 5'd2;
        tick();
        we  = 1'b0;
        ra1 = 5'd5;
        ra2 = 5'd5;
        #1;
        total++;
        if (rd1 !== 32'hDEAD_BEEF || rd2 !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL write_read got %h %h exp deadbeef", rd1, rd2);
        end
        total++;
        if (q1 !== 32'hDEAD_BEEF || q2 !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL write_read_nb got %h %h exp deadbeef", q1, q2);
        end
        for (int i = 0; i < 32; i++) begin
            if (i != 5) begin
                ra1 = 5'(i);
                ra2 = 5'(i);
                #1;
                total++;
                if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                    bad++;
                    $display("FAIL others_zero i=%0d got %h %h exp 0",
                             i, rd1, rd2);
                end
            end
        end
    endtask

    task automatic test_zero_reg();
        we  = 1'b1;
        wa  = 5'd0;
        wd  = 32'hFFFF_FFFF;
        ra1 = 5'd0;
        ra2 = 5'd0;
        #1;
        total++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            bad++;
            $display("FAIL zero_during got %h %h exp 0", rd1, rd2);
        end
        tick();
        we = 1'b0;
        #1;
        total++;
        if (rd1 !== 32'h0 || q1 !== 32'h0) begin
            bad++;
            $display("FAIL zero_after got %h %h exp 0", rd1, q1);
        end
    endtask

    task automatic test_bypass();
        we  = 1'b1;
        wa  = 5'd7;
        wd  = 32'h0000_0011;
        ra1 = 5'd1;
        ra2 = 5'd1;
        tick();
        wd  = 32'h0000_0022;
        ra1 = 5'd7;
        ra2 = 5'd7;
        #1;
        total++;
        if (rd1 !== 32'h22 || rd2 !== 32'h22) begin
            bad++;
            $display("FAIL bypass_on got %h %h exp 22", rd1, rd2);
        end
        total++;
        if (q1 !== 32'h11 || q2 !== 32'h11) begin
            bad++;
            $display("FAIL bypass_off got %h %h exp 11", q1, q2);
        end
        ra2 = 5'd5;
        #1;
        total++;
        if (rd1 !== 32'h22 || rd2 !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL bypass_indep got %h %h exp 22 deadbeef",
                     rd1, rd2);
        end
        ra2 = 5'd7;
        tick();
        we = 1'b0;
        #1;
        total++;
        if (q1 !== 32'h22 || q2 !== 32'h22 || rd1 !== 32'h22) begin
            bad++;
            $display("FAIL bypass_after got %h %h %h exp 22",
                     q1, q2, rd1);
        end
    endtask

    task automatic test_reset_priority();
        we  = 1'b1;
        wa  = 5'd3;
        wd  = 32'h1234_5678;
        ra1 = 5'd1;
        ra2 = 5'd1;
        tick();
        rst = 1'b1;
        wd  = 32'hAAAA_AAAA;
        ra1 = 5'd3;
        ra2 = 5'd3;
        #1;
        total++;
        if (rd1 !== 32'h1234_5678 || rd2 !== 32'h1234_5678) begin
            bad++;
            $display("FAIL rst_no_bypass got %h %h exp 12345678",
                     rd1, rd2);
        end
        tick();
        rst = 1'b0;
        we  = 1'b0;
        #1;
        total++;
        if (rd1 !== 32'h0 || q1 !== 32'h0) begin
            bad++;
            $display("FAIL rst_prio got %h %h exp 0", rd1, q1);
        end
        ra1 = 5'd7;
        ra2 = 5'd5;
        #1;
        total++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            bad++;
            $display("FAIL rst_clears_all got %h %h exp 0", rd1, rd2);
        end
    endtask

    task automatic test_reset_hold();
        rst = 1'b1;
        we  = 1'b1;
        wa  = 5'd9;
        wd  = 32'h5555_0009;
        repeat (3) tick();
        ra1 = 5'd9;
        ra2 = 5'd9;
        #1;
        total++;
        if (rd1 !== 32'h0 || q1 !== 32'h0) begin
            bad++;
            $display("FAIL rst_hold got %h %h exp 0", rd1, q1);
        end
        rst = 1'b0;
        tick();
        we = 1'b0;
        #1;
        total++;
        if (q1 !== 32'h5555_0009 || rd2 !== 32'h5555_0009) begin
            bad++;
            $display("FAIL first_write got %h %h exp 55550009",
                     q1, rd2);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e1;
        logic [31:0] e2;
        we = 1'b1;
        for (int i = 1; i < 32; i++) begin
            wa = 5'(i);
            wd = 32'(i) * 32'h0101_0101;
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'((i + 1) % 32);
            e1  = 32'(i) * 32'h0101_0101;
            e2  = 32'((i + 1) % 32) * 32'h0101_0101;
            #1;
            total++;
            if (rd1 !== e1 || rd2 !== e2) begin
                bad++;
                $display("FAIL b2b i=%0d got %h %h exp %h %h",
                         i, rd1, rd2, e1, e2);
            end
            total++;
            if (q1 !== e1 || q2 !== e2) begin
                bad++;
                $display("FAIL b2b_nb i=%0d got %h %h exp %h %h",
                         i, q1, q2, e1, e2);
            end
        end
    endtask

    task automatic test_mid_reset();
        we = 1'b1;
        wa = 5'd10;
        wd = 32'hCAFE_0010;
        tick();
        rst = 1'b1;
        wa  = 5'd11;
        wd  = 32'hCAFE_0011;
        tick();
        rst = 1'b0;
        wa  = 5'd12;
        wd  = 32'hCAFE_0012;
        tick();
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(i);
            #1;
            total++;
            if (i == 12) begin
                if (rd1 !== 32'hCAFE_0012 || q2 !== 32'hCAFE_0012) begin
                    bad++;
                    $display("FAIL mid_rst_new got %h %h exp cafe0012",
                             rd1, q2);
                end
            end else if (rd1 !== 32'h0 || q2 !== 32'h0) begin
                bad++;
                $display("FAIL mid_rst i=%0d got %h %h exp 0",
                         i, rd1, q2);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        we    = 1'b0;
        wa    = 5'd0;
        wd    = 32'h0;
        ra1   = 5'd0;
        ra2   = 5'd0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_reset_priority();
        test_reset_hold();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter BYPASS, default 1: 1 enables write-to-read forwarding, 0 disables it.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 ra1  input  5  read address, port 1.
REQ-005 ra2  input  5  read address, port 2.
REQ-006 rd1  output 32  read data, port 1; feeds ALU operand A and branch compare.
REQ-007 rd2  output 32  read data, port 2; feeds the b input of the ALU-source 2-to-1 mux and store data.
REQ-008 we  input  1  write enable.
REQ-009 wa  input  5  write address.
REQ-010 wd  input  32  write data, driven by the writeback-select 2-to-1 mux.

Function
REQ-011 Storage: 32 registers x 32 bits, indices 0..31; register 0 has no storage and always reads 32'h0000_0000.
REQ-012 Write: on rising clk with rst=0, we=1, wa!=0 -> reg[wa] <= wd; new value visible to non-bypassed reads after that edge.
REQ-013 Write to wa=0 -> no state change; no error indication.
REQ-014 we=0 -> no state change regardless of wa, wd.
REQ-015 Reads combinational (zero-cycle latency): rdN = reg[raN] from current stored state, raN=0 -> 0.
REQ-016 Bypass (BYPASS=1): if rst=0, we=1, wa!=0, wa==raN in the same cycle -> rdN = wd (combinational), independent per port.
REQ-017 Bypass applies to both ports simultaneously when ra1==ra2==wa.
REQ-018 BYPASS=0: rdN always returns stored value; same-cycle write visible only after the edge.
REQ-019 raN=0 -> rdN=0 even if we=1, wa=0, wd nonzero.
REQ-020 No X propagation: every rdN bit defined for every defined input combination after first reset edge.
REQ-021 Single write port: at most one register changes per clock edge.

Reset
REQ-022 rst=1 at rising clk -> registers 1..31 cleared to 32'h0000_0000 on that edge.
REQ-023 rst has priority over write: rst=1 and we=1 on same edge -> write discarded, register cleared.
REQ-024 While rst=1, bypass suppressed; rdN returns stored value (pre-clear before edge, 0 after).
REQ-025 rst held multiple cycles -> registers remain 0; first write accepted on first edge with rst=0.
REQ-026 Reset mid-operation (asserted between back-to-back writes) -> all prior writes lost; no partial state survives.
REQ-027 Contents before first reset edge undefined; outputs not checked until after it.

Verification
REQ-028 Reset then read all: rst=1 one edge, ra1/ra2 sweep 0..31 -> rd1=rd2=0 for every index.
REQ-029 Write/read: we=1, wa=5, wd=32'hDEAD_BEEF, edge; we=0, ra1=5, ra2=5 -> rd1=rd2=32'hDEAD_BEEF; other registers still 0.
REQ-030 Zero register: we=1, wa=0, wd=32'hFFFF_FFFF, edge; ra1=0 -> rd1=0; also rd1=0 during the write cycle.
REQ-031 Bypass: reg[7]=32'h0000_0011 stored; same cycle we=1, wa=7, wd=32'h0000_0022, ra1=7, ra2=7 -> BYPASS=1: rd1=rd2=32'h0000_0022 before edge; BYPASS=0: 32'h0000_0011 before edge, 32'h0000_0022 after.
REQ-032 Reset priority: reg[3]=32'h1234_5678; rst=1, we=1, wa=3, wd=32'hAAAA_AAAA on one edge -> rd of 3 = 32'h1234_5678 before edge (no bypass), 0 after edge.
REQ-033 Back-to-back writes: wa=1..31 with wd=index*32'h0101_0101 on consecutive edges, then read-back sweep -> every register holds its own value; no aliasing between ports.
